oscillator_phase: RTL and testbench
===================================

# oscillator_phase

Per-voice phase generator that drives the waveform shapers (triangle, and the other shapers that take the same inputs). On every audio sample tick it advances a fixed-point phase accumulator by a programmable increment. It reports the current half-cycle as `OSCILLATOR::oscillator_state_t` (FRONT/BACK) and the position within that half-cycle as a phase value. The shaper combinationally converts the `(state, phase)` pair into an audio sample.

## Interface
- `PHASE_WIDTH`, default 32: accumulator width. Integration sets it to `$bits(CONFIG::long_percent_t)`; benches may override.
- `clock`  in  1: system clock; all state changes on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `sample_tick`  in  1: one-cycle strobe at the audio sample rate; the only event that advances phase.
- `enable`  in  1: voice active (note on). Level.
- `sync`  in  1: one-cycle strobe requesting a phase restart (hard sync / retrigger).
- `increment`  in  PHASE_WIDTH: phase step per sample, in units of 1/2^PHASE_WIDTH of a half-cycle. Sampled only on tick cycles.
- `state`  out  `OSCILLATOR::oscillator_state_t`: current half-cycle.
- `phase`  out  PHASE_WIDTH: position within the half-cycle, 0 to 2^PHASE_WIDTH−1. Increases in both halves.
- `sample_valid`  out  1: one-cycle pulse marking freshly updated `state`/`phase`.
- `cycle_wrap`  out  1: one-cycle pulse when a full period completes (BACK→FRONT by carry).

## Operation
- FSM states:
  - IDLE: `phase=0`, `state=FRONT`.
  - RUN.
- IDLE→RUN: on the first tick with `enable=1`. That tick outputs `phase=0`, `state=FRONT` (no advance) and pulses `sample_valid`.
- RUN→IDLE: on any cycle with `enable=0`, tick or not. Phase and state clear to 0/FRONT immediately. No pulses.
- RUN, tick:
  - `{carry, next} = phase + increment`, computed in PHASE_WIDTH+1 bits. `phase ← next` (truncated).
  - If `carry`, `state` toggles.
  - If `carry` and old `state=BACK`, pulse `cycle_wrap`.
  - Always pulse `sample_valid`.
  - At most one carry per tick, because `increment < 2^PHASE_WIDTH`.
- `increment=0`: phase holds. `sample_valid` still pulses on each tick.
- `sync`:
  - Sets a `sync_pending` flag.
  - On the next tick in RUN: `phase←0`, `state←FRONT`, no `cycle_wrap`, and the flag clears.
  - If `sync` and tick occur in the same cycle, the sync applies on that tick.
  - `sync_pending` clears on any transition to IDLE.
- Changes on `increment` between ticks have no effect. The value present on the tick cycle is used.

## Timing
- Reset values: FSM=IDLE, `state=FRONT`, `phase=0`, `sample_valid=0`, `cycle_wrap=0`, `sync_pending=0`.
- Reset has priority over all inputs. Reset mid-RUN returns to IDLE on the next edge.
- All outputs are registered. Updates from a tick in cycle N are visible in cycle N+1, together with `sample_valid`/`cycle_wrap`.
- `sample_valid` and `cycle_wrap` are high for exactly one cycle per tick.
- Ticks must be at least 2 cycles apart. Back-to-back ticks are still processed one per cycle with no loss.
- Priority per cycle: `reset` > `enable=0` > `sync` (pending or same-cycle) > accumulate.

## Test plan
- Reset and idle, PHASE_WIDTH=8, enable=0:
  - Stimulus: reset for 2 cycles, then 5 ticks.
  - Required: `state=FRONT`, `phase=0`, no `sample_valid`, no `cycle_wrap`.
- Start and accumulate, enable=1, increment=64:
  - Stimulus: ticks.
  - Required phase sequence: 0, 64, 128, 192, then 0 with state BACK, then 64, 128, 192, then 0 with FRONT and `cycle_wrap` pulse.
  - `sample_valid` pulses once per tick, one cycle after each tick.
- Non-dividing step, increment=100:
  - Required phases: 0, 100, 200, 44 (BACK), 144, 244, 88 (FRONT, `cycle_wrap`).
  - Confirms the remainder is carried across the wrap.
- Sync:
  - From phase=200 in BACK, pulse `sync` 1 cycle before a tick → that tick gives `phase=0`, `FRONT`, no `cycle_wrap`.
  - Repeat with `sync` coincident with the tick → same result.
- Enable drop and restart:
  - Deassert `enable` between ticks at phase=128/BACK → next cycle shows `phase=0`/`FRONT`.
  - Reassert → first tick outputs `phase=0`.
  - A pending sync is discarded.
- Increment edge cases:
  - increment=255 → phase 0, 255, 254 (state toggled), 253 (toggled again).
  - increment=0 → phase constant; `sample_valid` still pulses on each tick.
  - Changing `increment` between ticks has no effect until the next tick.

Source files
------------

// File: rtl/oscillator_phase_if.sv
// Shared half-cycle type and the voice-oscillator bus.
// The controller side (master) drives the tick, enable, sync and increment
// inputs; the oscillator (slave) returns state, phase and the two strobes.

package OSCILLATOR;
    typedef enum logic {
        FRONT = 1'b0,
        BACK  = 1'b1
    } oscillator_state_t;
endpackage

interface oscillator_phase_if #(
    parameter int PHASE_WIDTH = 32
);
    logic                          sample_tick;
    logic                          enable;
    logic                          sync;
    logic [PHASE_WIDTH-1:0]        increment;
    OSCILLATOR::oscillator_state_t state;
    logic [PHASE_WIDTH-1:0]        phase;
    logic                          sample_valid;
    logic                          cycle_wrap;

    modport master (
        output sample_tick, enable, sync, increment,
        input  state, phase, sample_valid, cycle_wrap
    );

    modport slave (
        input  sample_tick, enable, sync, increment,
        output state, phase, sample_valid, cycle_wrap
    );
endinterface

// File: rtl/oscillator_phase.sv
// Per-voice phase accumulator feeding the waveform shapers.
// A full period is two half-cycles (FRONT then BACK); phase counts up from
// zero in each half and the carry out of the accumulator flips the half.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | voice off; phase held at 0 / FRONT, sync requests ignored
// RUN   | voice on; each sample tick advances or restarts the phase

module oscillator_phase #(
    parameter int PHASE_WIDTH = 32
) (
    input  logic               clock,
    input  logic               reset,
    oscillator_phase_if.slave  bus
);
    import OSCILLATOR::*;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fsm_t;

    fsm_t                 fsm;
    logic                 sync_pending;
    logic [PHASE_WIDTH:0] sum;

    // One extra bit catches the carry that marks the end of a half-cycle.
    assign sum = {1'b0, bus.phase} + {1'b0, bus.increment};

    // Sequencer: enable drop beats sync, sync beats accumulation.
    always_ff @(posedge clock) begin
        if (reset) begin
            fsm              <= IDLE;
            sync_pending     <= 1'b0;
            bus.state        <= FRONT;
            bus.phase        <= '0;
            bus.sample_valid <= 1'b0;
            bus.cycle_wrap   <= 1'b0;
        end else begin
            bus.sample_valid <= 1'b0;
            bus.cycle_wrap   <= 1'b0;
            if (!bus.enable) begin
                fsm          <= IDLE;
                sync_pending <= 1'b0;
                bus.state    <= FRONT;
                bus.phase    <= '0;
            end else if (fsm == IDLE) begin
                // The start tick is itself a restart, so a sync seen while
                // idle has nothing left to do.
                sync_pending <= 1'b0;
                if (bus.sample_tick) begin
                    fsm              <= RUN;
                    bus.state        <= FRONT;
                    bus.phase        <= '0;
                    bus.sample_valid <= 1'b1;
                end
            end else if (bus.sample_tick) begin
                bus.sample_valid <= 1'b1;
                sync_pending     <= 1'b0;
                if (bus.sync || sync_pending) begin
                    bus.state <= FRONT;
                    bus.phase <= '0;
                end else begin
                    bus.phase <= sum[PHASE_WIDTH-1:0];
                    if (sum[PHASE_WIDTH]) begin
                        bus.state <= (bus.state == FRONT) ? BACK : FRONT;
                        if (bus.state == BACK) begin
                            bus.cycle_wrap <= 1'b1;
                        end
                    end
                end
            end else if (bus.sync) begin
                sync_pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_oscillator_phase.sv
// Bench for oscillator_phase at PHASE_WIDTH=8: a table of hand-computed
// cycle vectors, then random traffic against a period-position model.

module tb_oscillator_phase;
    localparam int W   = 8;
    localparam int HALF = 1 << W;
    localparam int FULL = 2 << W;
    localparam logic F = 1'b0;
    localparam logic B = 1'b1;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    oscillator_phase_if #(.PHASE_WIDTH(W)) bus ();

    oscillator_phase #(.PHASE_WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic       r, t, s, e;
        logic [7:0] inc;
        logic       st;
        logic [7:0] ph;
        logic       v, w;
    } vec_t;

    vec_t vecs[$];
    int   tests = 0;
    int   fails = 0;

    // Reference: position within the whole period, 0 .. 2*2^W-1.
    bit m_run, m_pend, m_v, m_w;
    int m_pos;

    task automatic add(input logic r, t, s, e, input int inc,
                       input logic st, input int ph, input logic v, w);
        vec_t x;
        x.r = r; x.t = t; x.s = s; x.e = e;
        x.inc = inc[7:0]; x.st = st; x.ph = ph[7:0]; x.v = v; x.w = w;
        vecs.push_back(x);
    endtask

    task automatic tk(input int inc, input logic st, input int ph, input logic w);
        add(0, 1, 0, 1, inc, st, ph, 1, w);
    endtask

    task automatic gp(input logic st, input int ph);
        add(0, 0, 0, 1, 0, st, ph, 0, 0);
    endtask

    task automatic drive(input logic r, t, s, e, input logic [7:0] inc);
        reset           = r;
        bus.sample_tick = t;
        bus.sync        = s;
        bus.enable      = e;
        bus.increment   = inc;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic st, input logic [7:0] ph,
                         input logic v, input logic w);
        logic got_st;
        got_st = (bus.state == OSCILLATOR::BACK);
        tests++;
        if (got_st !== st || bus.phase !== ph || bus.sample_valid !== v ||
            bus.cycle_wrap !== w) begin
            fails++;
            $display("FAIL %s: got state=%0d phase=%0d valid=%0d wrap=%0d, expected state=%0d phase=%0d valid=%0d wrap=%0d",
                     name, got_st, bus.phase, bus.sample_valid, bus.cycle_wrap,
                     st, ph, v, w);
        end
    endtask

    task automatic model_step(input bit r, t, s, e, input int inc);
        m_v = 0;
        m_w = 0;
        if (r) begin
            m_run = 0; m_pos = 0; m_pend = 0;
        end else if (!e) begin
            m_run = 0; m_pos = 0; m_pend = 0;
        end else if (!m_run) begin
            if (t) begin
                m_run = 1; m_pos = 0; m_v = 1;
            end
        end else if (t) begin
            m_v = 1;
            if (m_pend || s) begin
                m_pos = 0;
            end else begin
                if (m_pos + inc >= FULL) m_w = 1;
                m_pos = (m_pos + inc) % FULL;
            end
            m_pend = 0;
        end else if (s) begin
            m_pend = 1;
        end
    endtask

    initial begin
        bit r, t, s, e, en_lvl;
        int inc;

        // reset, then ticks with the voice off
        add(1, 0, 0, 0, 0, F, 0, 0, 0);
        add(1, 0, 0, 0, 0, F, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            add(0, 1, 0, 0, 0, F, 0, 0, 0);
            add(0, 0, 0, 0, 0, F, 0, 0, 0);
        end
        // increment 64: one full period
        tk(64, F, 0, 0);   gp(F, 0);
        tk(64, F, 64, 0);  gp(F, 64);
        tk(64, F, 128, 0); gp(F, 128);
        tk(64, F, 192, 0); gp(F, 192);
        tk(64, B, 0, 0);   gp(B, 0);
        tk(64, B, 64, 0);  gp(B, 64);
        tk(64, B, 128, 0); gp(B, 128);
        tk(64, B, 192, 0); gp(B, 192);
        tk(64, F, 0, 1);   gp(F, 0);
        add(0, 0, 0, 0, 0, F, 0, 0, 0);
        // increment 100: remainder crosses the wrap
        tk(100, F, 0, 0);   gp(F, 0);
        tk(100, F, 100, 0); gp(F, 100);
        tk(100, F, 200, 0); gp(F, 200);
        tk(100, B, 44, 0);  gp(B, 44);
        tk(100, B, 144, 0); gp(B, 144);
        tk(100, B, 244, 0); gp(B, 244);
        tk(100, F, 88, 1);  gp(F, 88);
        add(0, 0, 0, 0, 0, F, 0, 0, 0);
        // sync one cycle ahead of the tick, from 200/BACK
        tk(5, F, 0, 0);     gp(F, 0);
        tk(100, F, 100, 0); gp(F, 100);
        tk(100, F, 200, 0); gp(F, 200);
        tk(56, B, 0, 0);    gp(B, 0);
        tk(200, B, 200, 0);
        add(0, 0, 1, 1, 0, B, 200, 0, 0);
        tk(100, F, 0, 0);   gp(F, 0);
        // sync on the tick cycle itself
        tk(100, F, 100, 0); gp(F, 100);
        tk(100, F, 200, 0); gp(F, 200);
        tk(56, B, 0, 0);    gp(B, 0);
        tk(200, B, 200, 0); gp(B, 200);
        add(0, 1, 1, 1, 100, F, 0, 1, 0);
        gp(F, 0);
        // enable drop at 128/BACK with a sync pending, then restart
        tk(128, F, 128, 0); gp(F, 128);
        tk(128, B, 0, 0);   gp(B, 0);
        tk(128, B, 128, 0); gp(B, 128);
        add(0, 0, 1, 1, 0, B, 128, 0, 0);
        add(0, 0, 0, 0, 0, F, 0, 0, 0);
        gp(F, 0);
        tk(64, F, 0, 0);    gp(F, 0);
        tk(64, F, 64, 0);   gp(F, 64);
        // increment 255
        add(0, 0, 0, 0, 0, F, 0, 0, 0);
        tk(255, F, 0, 0);   gp(F, 0);
        tk(255, F, 255, 0); gp(F, 255);
        tk(255, B, 254, 0); gp(B, 254);
        tk(255, F, 253, 1); gp(F, 253);
        // increment 0
        tk(0, F, 253, 0);   gp(F, 253);
        tk(0, F, 253, 0);   gp(F, 253);
        // increment changes between ticks are ignored
        add(0, 0, 0, 1, 77, F, 253, 0, 0);
        add(0, 0, 0, 1, 200, F, 253, 0, 0);
        tk(10, B, 7, 0);
        add(0, 0, 0, 1, 200, B, 7, 0, 0);
        tk(3, B, 10, 0);
        // back-to-back ticks
        tk(3, B, 13, 0);
        tk(3, B, 16, 0);
        gp(B, 16);
        // reset mid-run wins over a tick
        add(1, 1, 0, 1, 50, F, 0, 0, 0);
        gp(F, 0);
        tk(5, F, 0, 0);
        tk(5, F, 5, 0);
        gp(F, 5);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].r, vecs[i].t, vecs[i].s, vecs[i].e, vecs[i].inc);
            check($sformatf("vec%0d", i), vecs[i].st, vecs[i].ph, vecs[i].v, vecs[i].w);
        end

        // random traffic against the reference
        en_lvl = 1;
        for (int n = 0; n < 4000; n++) begin
            r = (n == 0) || ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 59) == 0) en_lvl = !en_lvl;
            e = en_lvl;
            t = ($urandom_range(0, 2) == 0);
            s = ($urandom_range(0, 14) == 0);
            case ($urandom_range(0, 9))
                0:       inc = 0;
                1:       inc = HALF - 1;
                2:       inc = 1;
                default: inc = $urandom_range(0, HALF - 1);
            endcase
            model_step(r, t, s, e, inc);
            drive(r, t, s, e, inc[7:0]);
            check("rand", (m_pos >= HALF), 8'(m_pos % HALF), m_v, m_w);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
